// File: rtl/mmio_note_seq_if.sv
// CPU-side MMIO slot bus of the note sequencer: select, strobes, address and data.
interface mmio_note_seq_if;
    logic        cs;
    logic        write;
    logic        read;
    logic [4:0]  addr;
    logic [31:0] write_data;
    logic [31:0] read_data;

    // Strobe protocol, no back-pressure: a write is accepted on every clock edge where
    // cs && write; read_data follows addr combinationally and has no side effects.
    modport master (output cs, write, read, addr, write_data, input  read_data);
    modport slave  (input  cs, write, read, addr, write_data, output read_data);
endinterface

// File: rtl/mmio_note_seq.sv
// Note sequencer MMIO slot: a FIFO of {tuning word, duration, gate} entries played on the audio tick.
// Optional macro NOTE_SEQ_LOOP_EN: ctrl.loop recirculates each popped entry to the FIFO tail.
module mmio_note_seq #(
    parameter int FIFO_AW = 4,
    parameter int FREQ_W  = 30,
    parameter int DUR_W   = 16
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    mmio_note_seq_if.slave    bus,
    input  logic              i_tick,
    output logic [FREQ_W-1:0] o_fccw,
    output logic              o_note_on,
    output logic              o_note_off,
    output logic              o_gate,
    output logic [1:0]        o_dbg_state
);
    localparam int DEPTH = 2 ** FIFO_AW;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PLAY = 2'd2
    } state_t;

    typedef struct packed {
        logic [FREQ_W-1:0] freq;
        logic [DUR_W-1:0]  dur;
        logic [DUR_W-1:0]  gate;
    } entry_t;

    state_t             state;
    state_t             state_next;

    entry_t             mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               empty;
    logic               full;

    logic [FREQ_W-1:0]  freq_stage;
    entry_t             cur;
    entry_t             push_entry;
    logic [DUR_W-1:0]   rem;
    logic [DUR_W-1:0]   el;
    logic [DUR_W-1:0]   gate_len;
    logic               ctrl_run;
    logic               ctrl_loop;
    logic               ovf;

    logic               wr_en;
    logic               wr_freq;
    logic               wr_push;
    logic               wr_ctrl;
    logic               flush;
    logic               clr_ovf;
    logic               push_ok;
    logic               push_drop;
    logic               pop;
    logic               recirc;
    logic               load;
    logic               tick_play;
    logic               last_tick;
    logic               gate_hit;
    logic [31:0]        read_mux;

    assign wr_en   = bus.cs && bus.write;
    assign wr_freq = wr_en && (bus.addr == 5'd0);
    assign wr_push = wr_en && (bus.addr == 5'd1);
    assign wr_ctrl = wr_en && (bus.addr == 5'd2);
    assign flush   = wr_ctrl && bus.write_data[1];
    assign clr_ovf = wr_ctrl && bus.write_data[2];

    assign empty = (count == '0);
    assign full  = (count == (FIFO_AW+1)'(DEPTH));

    assign push_entry.freq = freq_stage;
    assign push_entry.dur  = bus.write_data[DUR_W-1:0];
    assign push_entry.gate = bus.write_data[16+DUR_W-1:16];

    // In loop mode the popped entry owns the tail write port, so CPU pushes are refused.
    assign recirc    = pop && ctrl_loop;
    assign push_ok   = wr_push && !full && !ctrl_loop;
    assign push_drop = wr_push && (full || ctrl_loop);

    assign tick_play = (state == ST_PLAY) && i_tick;
    assign last_tick = tick_play && (rem == DUR_W'(1));
    assign gate_hit  = tick_play && (gate_len != '0) &&
                       (({1'b0, el} + (DUR_W+1)'(1)) == {1'b0, gate_len});

    assign o_dbg_state = state;

`ifdef NOTE_SEQ_LOOP_EN
    logic loop_reg;
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            loop_reg <= 1'b0;
        end else if (wr_ctrl) begin
            loop_reg <= bus.write_data[3];
        end
    end
    assign ctrl_loop = loop_reg;
`else
    assign ctrl_loop = 1'b0;
`endif

    // ---------------- sequencing FSM ----------------
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        load       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ctrl_run && !empty) begin
                    pop        = 1'b1;
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                load       = 1'b1;
                state_next = ST_PLAY;
            end
            ST_PLAY: begin
                // Chaining the pop onto the last tick gives gapless back-to-back notes.
                if (last_tick) begin
                    if (ctrl_run && !empty) begin
                        pop        = 1'b1;
                        state_next = ST_LOAD;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (flush) begin
            state_next = ST_IDLE;
            pop        = 1'b0;
            load       = 1'b0;
        end
    end

    // ---------------- FIFO ----------------
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + FIFO_AW'(1);
            end
            if (push_ok || recirc) begin
                wr_ptr <= wr_ptr + FIFO_AW'(1);
            end
            if (push_ok && !pop) begin
                count <= count + (FIFO_AW+1)'(1);
            end else if (pop && !push_ok && !recirc) begin
                count <= count - (FIFO_AW+1)'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (recirc) begin
            mem[wr_ptr] <= mem[rd_ptr];
        end else if (push_ok) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // ---------------- voice outputs and note timers ----------------
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            o_fccw     <= '0;
            o_note_on  <= 1'b0;
            o_note_off <= 1'b0;
            o_gate     <= 1'b0;
            rem        <= '0;
            el         <= '0;
            gate_len   <= '0;
            cur        <= '0;
        end else begin
            o_note_on  <= 1'b0;
            o_note_off <= 1'b0;
            if (pop) begin
                cur <= mem[rd_ptr];
            end
            if (flush) begin
                o_note_off <= o_gate;
                o_gate     <= 1'b0;
            end else if (load) begin
                o_fccw    <= cur.freq;
                o_note_on <= 1'b1;
                o_gate    <= 1'b1;
                rem       <= (cur.dur == '0) ? DUR_W'(1) : cur.dur;
                el        <= '0;
                gate_len  <= cur.gate;
            end else if (tick_play) begin
                rem <= rem - DUR_W'(1);
                el  <= el + DUR_W'(1);
                // An early release and the note end can coincide; o_gate keeps it to one pulse.
                if (o_gate && (gate_hit || last_tick)) begin
                    o_note_off <= 1'b1;
                    o_gate     <= 1'b0;
                end
            end
        end
    end

    // ---------------- CPU registers ----------------
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            freq_stage <= '0;
            ctrl_run   <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            if (wr_freq) begin
                freq_stage <= bus.write_data[FREQ_W-1:0];
            end
            if (wr_ctrl) begin
                ctrl_run <= bus.write_data[0];
            end
            if (push_drop) begin
                ovf <= 1'b1;
            end else if (clr_ovf) begin
                ovf <= 1'b0;
            end
        end
    end

    always_comb begin
        read_mux = '0;
        case (bus.addr)
            5'd0: read_mux = {16'b0, 8'(count), 4'b0, ovf, (state != ST_IDLE), full, empty};
            5'd1: read_mux = 32'(rem);
            5'd2: read_mux = {28'b0, ctrl_loop, 2'b0, ctrl_run};
            default: read_mux = '0;
        endcase
    end

    assign bus.read_data = read_mux;

endmodule

// File: tb/tb_mmio_note_seq.sv
// Bench for mmio_note_seq: register vector table, directed note sequences and random traffic
// checked every cycle against a queue-based note model.
`timescale 1ns/1ps
module tb_mmio_note_seq;
    localparam int FIFO_AW = 4;
    localparam int FREQ_W  = 30;
    localparam int DUR_W   = 16;
    localparam int DEPTH   = 16;
`ifdef NOTE_SEQ_LOOP_EN
    localparam bit LOOP_EN = 1'b1;
`else
    localparam bit LOOP_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic              clk;
    logic              rst_n;
    logic              tick;
    logic [FREQ_W-1:0] fccw;
    logic              note_on;
    logic              note_off;
    logic              gate;
    logic [1:0]        dbg_state;

    mmio_note_seq_if bus ();

    mmio_note_seq #(.FIFO_AW(FIFO_AW), .FREQ_W(FREQ_W), .DUR_W(DUR_W)) dut (
        .i_clk       (clk),
        .i_reset_n   (rst_n),
        .bus         (bus),
        .i_tick      (tick),
        .o_fccw      (fccw),
        .o_note_on   (note_on),
        .o_note_off  (note_off),
        .o_gate      (gate),
        .o_dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model (note level, queue based) ----------------
    typedef struct {
        int unsigned f;
        int unsigned d;
        int unsigned g;
    } note_t;

    note_t       m_q[$];
    note_t       m_cur;
    int unsigned m_stage, m_fccw, m_rem, m_el;
    int          m_phase;  // 0 waiting, 1 about to sound, 2 sounding
    bit          m_run, m_loop, m_ovf, m_on, m_off, m_gate;

    task automatic model_step();
        bit          wr, fl, do_pop, full_before;
        logic [31:0] wd;
        if (!rst_n) begin
            m_q.delete();
            m_cur   = '{0, 0, 0};
            m_stage = 0; m_fccw = 0; m_rem = 0; m_el = 0; m_phase = 0;
            m_run = 0; m_loop = 0; m_ovf = 0; m_on = 0; m_off = 0; m_gate = 0;
            return;
        end
        wr          = bus.cs && bus.write;
        wd          = bus.write_data;
        fl          = wr && (bus.addr == 5'd2) && wd[1];
        full_before = (m_q.size() == DEPTH);
        m_on = 0; m_off = 0; do_pop = 0;
        if (fl) begin
            if (m_gate) m_off = 1;
            m_gate  = 0;
            m_phase = 0;
            m_q.delete();
        end else if (m_phase == 0) begin
            if (m_run && m_q.size() > 0) begin do_pop = 1; m_phase = 1; end
        end else if (m_phase == 1) begin
            m_fccw = m_cur.f; m_on = 1; m_gate = 1;
            m_rem  = (m_cur.d == 0) ? 1 : m_cur.d;
            m_el   = 0; m_phase = 2;
        end else if (tick) begin
            // release on tick number 'gate' counted from note start, or at the last tick
            if (m_gate && ((m_cur.g != 0 && m_el + 1 == m_cur.g) || m_rem == 1)) begin
                m_off = 1; m_gate = 0;
            end
            if (m_rem == 1) begin
                if (m_run && m_q.size() > 0) begin do_pop = 1; m_phase = 1; end
                else m_phase = 0;
            end
            m_rem--; m_el++;
        end
        if (do_pop) begin
            m_cur = m_q.pop_front();
            if (m_loop) m_q.push_back(m_cur);
        end
        if (wr && bus.addr == 5'd0) m_stage = wd & 32'h3FFF_FFFF;
        if (wr && bus.addr == 5'd1) begin
            if (full_before || m_loop) m_ovf = 1;
            else m_q.push_back('{m_stage, 32'(wd[15:0]), 32'(wd[31:16])});
        end
        if (wr && bus.addr == 5'd2) begin
            m_run = wd[0];
            if (LOOP_EN) m_loop = wd[3];
            if (wd[2]) m_ovf = 0;
        end
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a);
        case (a)
            5'd0: return {16'b0, 8'(m_q.size()), 4'b0, m_ovf, (m_phase != 0),
                          (m_q.size() == DEPTH), (m_q.size() == 0)};
            5'd1: return m_rem;
            5'd2: return {28'b0, m_loop, 2'b0, m_run};
            default: return 32'h0;
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        bus.cs    = 1'b0;
        bus.write = 1'b0;
        tick      = 1'b0;
        check("fccw",      32'(fccw),           m_fccw);
        check("note_on",   32'(note_on),        32'(m_on));
        check("note_off",  32'(note_off),       32'(m_off));
        check("gate",      32'(gate),           32'(m_gate));
        check("busy_dbg",  32'(dbg_state != 0), 32'(m_phase != 0));
        check("read_data", bus.read_data,       model_read(bus.addr));
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        bus.cs = 1'b1; bus.write = 1'b1; bus.addr = a; bus.write_data = d;
        cycle();
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string name);
        bus.addr = a;
        #1;
        check(name, bus.read_data, exp);
    endtask

    task automatic wait_note_on(input string name);
        bit seen = 0;
        for (int i = 0; i < 8 && !seen; i++) begin
            cycle();
            if (note_on) seen = 1;
        end
        check(name, 32'(seen), 32'd1);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit          do_wr;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [4:0]  raddr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int ons;
        int k;
        logic [31:0] loop_exp[4];

        vecs[0] = '{1'b0, 5'd0, 32'h0,        5'd0,  32'h0000_0001};
        vecs[1] = '{1'b0, 5'd0, 32'h0,        5'd1,  32'h0};
        vecs[2] = '{1'b0, 5'd0, 32'h0,        5'd2,  32'h0};
        vecs[3] = '{1'b1, 5'd2, 32'h1,        5'd2,  32'h1};
        vecs[4] = '{1'b1, 5'd2, 32'hF,        5'd2,  LOOP_EN ? 32'h9 : 32'h1};
        vecs[5] = '{1'b1, 5'd2, 32'h0,        5'd2,  32'h0};
        vecs[6] = '{1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 32'h0000_0001};
        vecs[7] = '{1'b0, 5'd0, 32'h0,        5'd3,  32'h0};
        vecs[8] = '{1'b0, 5'd0, 32'h0,        5'd31, 32'h0};

        rst_n = 1'b0; tick = 1'b0;
        bus.cs = 1'b0; bus.write = 1'b0; bus.read = 1'b0; bus.addr = 5'd0; bus.write_data = 32'h0;
        repeat (3) cycle();
        rst_n = 1'b1;
        check("reset_fccw",     32'(fccw),     32'h0);
        check("reset_note_on",  32'(note_on),  32'h0);
        check("reset_note_off", 32'(note_off), 32'h0);
        check("reset_gate",     32'(gate),     32'h0);

        foreach (vecs[i]) begin
            if (vecs[i].do_wr) wr(vecs[i].waddr, vecs[i].wdata);
            rd(vecs[i].raddr, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // single note A: f=0x1000 dur=4 gate=2
        wr(5'd0, 32'h1000); wr(5'd1, {16'd2, 16'd4}); wr(5'd2, 32'h1);
        wait_note_on("a_note_on");
        check("a_fccw", 32'(fccw), 32'h1000);
        check("a_gate", 32'(gate), 32'h1);
        for (int t = 1; t <= 4; t++) begin
            tick = 1'b1; cycle();
            check($sformatf("a_off_tick%0d", t), 32'(note_off), 32'(t == 2));
        end
        rd(5'd0, 32'h0000_0001, "a_idle_status");

        // push while idle and running: note_on two cycles later; then B chained gaplessly
        wr(5'd0, 32'h1000); wr(5'd1, {16'd2, 16'd4});
        cycle(); check("lat_not_yet", 32'(note_on), 32'h0);
        cycle(); check("lat_note_on", 32'(note_on), 32'h1);
        wr(5'd0, 32'h2000); wr(5'd1, {16'd0, 16'd3});
        for (int t = 1; t <= 4; t++) begin tick = 1'b1; cycle(); end
        cycle();
        check("b_note_on", 32'(note_on), 32'h1);
        check("b_fccw",    32'(fccw),    32'h2000);
        ons = 0;
        for (int t = 1; t <= 3; t++) begin
            tick = 1'b1; cycle();
            if (note_off) ons++;
            check($sformatf("b_off_tick%0d", t), 32'(note_off), 32'(t == 3));
        end
        check("b_single_off", 32'(ons), 32'd1);
        rd(5'd0, 32'h0000_0001, "b_idle_status");

        // overflow: 17 pushes into 16 entries, then clear ovf and flush
        wr(5'd2, 32'h0);
        for (int i = 0; i < 17; i++) wr(5'd1, {16'd1, 16'd2});
        rd(5'd0, 32'h0000_100A, "ovf_full_status");
        wr(5'd2, 32'h4);
        rd(5'd0, 32'h0000_1002, "ovf_cleared");
        wr(5'd2, 32'h2);
        rd(5'd0, 32'h0000_0001, "ovf_flushed");

        // flush mid-note with the gate open
        wr(5'd0, 32'h3000); wr(5'd1, {16'd0, 16'd100}); wr(5'd2, 32'h1);
        wait_note_on("fl_note_on");
        for (int t = 0; t < 3; t++) begin tick = 1'b1; cycle(); end
        wr(5'd1, {16'd0, 16'd5});
        wr(5'd2, 32'h3);
        check("fl_note_off", 32'(note_off), 32'h1);
        check("fl_gate",     32'(gate),     32'h0);
        rd(5'd0, 32'h0000_0001, "fl_status");
        ons = 0;
        for (int i = 0; i < 12; i++) begin tick = 1'b1; cycle(); if (note_on) ons++; end
        check("fl_no_note_on", 32'(ons), 32'd0);

        if (LOOP_EN) begin
            loop_exp = '{32'h111, 32'h222, 32'h111, 32'h222};
            wr(5'd2, 32'h0);
            wr(5'd0, 32'h111); wr(5'd1, {16'd0, 16'd2});
            wr(5'd0, 32'h222); wr(5'd1, {16'd0, 16'd2});
            wr(5'd2, 32'h9);
            k = 0;
            for (int i = 0; i < 60 && k < 4; i++) begin
                tick = 1'b1; cycle();
                if (note_on) begin
                    check($sformatf("loop_note%0d", k), 32'(fccw), loop_exp[k]);
                    k++;
                end
            end
            check("loop_count_notes", 32'(k), 32'd4);
            rd(5'd0, 32'h0000_0204, "loop_status");
            wr(5'd1, {16'd0, 16'd2});
            rd(5'd0, 32'h0000_020C, "loop_push_ovf");
            wr(5'd2, 32'h2);
        end

        // randomized traffic, checked every cycle by the model
        wr(5'd2, 32'h6);
        for (int i = 0; i < 1500; i++) begin
            int r;
            r    = $urandom_range(0, 99);
            tick = 1'($urandom_range(0, 1));
            if (r < 10) begin
                bus.cs = 1'b1; bus.write = 1'b1; bus.addr = 5'd0; bus.write_data = $urandom;
            end else if (r < 28) begin
                bus.cs = 1'b1; bus.write = 1'b1; bus.addr = 5'd1;
                bus.write_data = {16'($urandom_range(0, 6)), 16'($urandom_range(0, 5))};
            end else if (r < 34) begin
                bus.cs = 1'b1; bus.write = 1'b1; bus.addr = 5'd2;
                bus.write_data = {28'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                                  1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 3) != 0)};
            end else begin
                bus.addr = (r < 96) ? 5'($urandom_range(0, 3)) : 5'd9;
            end
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
